aes_arb_ctrl: RTL and testbench

AES_ARB_CTRL -- requirements
Module: aes_arb_ctrl

---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_rr_arb2.sv | 32 +++
 rtl/aes_arb_ctrl.sv | 130 +++++++++++++
 tb/tb_aes_arb_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and defaults for the AES job arbiter and its round-robin grant logic.
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StResp,
    StGap
  } aes_arb_state_e;

  localparam int unsigned TimeoutCycDefault = 100;
  localparam int unsigned GapCycDefault     = 2;

  // Bits needed to count 0 .. max(a, b) - 1.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is actually issued.
module aes_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // prio_q = 1 means requester 1 wins the next tie.
  logic prio_q, prio_d;

  always_comb begin
    gnt_o  = 2'b00;
    prio_d = prio_q;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
      if (gnt_o != 2'b00) prio_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prio_q <= 1'b0;
    else         prio_q <= prio_d;
  end

endmodule

// File: rtl/aes_arb_ctrl.sv
// Arbitrates two AES job requesters onto a single AES core, with timeout abort and
// response hold-off under consumer backpressure.
module aes_arb_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault,
  parameter int unsigned GAP_CYC     = GapCycDefault
) (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic         resp_err,
  output logic [127:0] resp_data,
  output logic         core_en,
  output logic [127:0] core_data_in,
  output logic [127:0] core_key_in,
  input  logic [127:0] core_data_out,
  input  logic         core_data_out_valid
);

  localparam int unsigned CntW = cnt_width(TIMEOUT_CYC, GAP_CYC);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);
  localparam logic [CntW-1:0] GapLast     = CntW'(GAP_CYC - 1);

  aes_arb_state_e  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  aes_block_t      op_data_q, op_data_d;
  aes_block_t      op_key_q, op_key_d;
  aes_block_t      resp_data_q, resp_data_d;
  logic            resp_id_q, resp_id_d;
  logic            resp_err_q, resp_err_d;
  logic [1:0]      gnt;

  aes_rr_arb2 u_arb (
    .clk_i  (AES_clk),
    .rst_ni (AES_rst_n),
    .en_i   (state_q == StIdle),
    .req_i  ({req1_valid, req0_valid}),
    .gnt_o  (gnt)
  );

  // Grants are combinational in IDLE; masking with reset keeps ready low while held in reset.
  assign req0_ready   = gnt[0] & AES_rst_n;
  assign req1_ready   = gnt[1] & AES_rst_n;

  assign core_en      = (state_q == StRun);
  assign core_data_in = op_data_q;
  assign core_key_in  = op_key_q;
  assign resp_valid   = (state_q == StResp);
  assign resp_id      = resp_id_q;
  assign resp_err     = resp_err_q;
  assign resp_data    = resp_data_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_data_d   = op_data_q;
    op_key_d    = op_key_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    resp_err_d  = resp_err_q;
    unique case (state_q)
      StIdle: begin
        if (gnt != 2'b00) begin
          op_data_d = gnt[1] ? req1_data : req0_data;
          op_key_d  = gnt[1] ? req1_key  : req0_key;
          resp_id_d = gnt[1];
          cnt_d     = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        // A result arriving on the final cycle still beats the timeout.
        if (core_data_out_valid) begin
          resp_data_d = core_data_out;
          resp_err_d  = 1'b0;
          state_d     = StResp;
        end else if (cnt_q == TimeoutLast) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        if (resp_ready) begin
          cnt_d   = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) state_d = StIdle;
        else                  cnt_d   = cnt_q + CntW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_data_q   <= '0;
      op_key_q    <= '0;
      resp_data_q <= '0;
      resp_id_q   <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_data_q   <= op_data_d;
      op_key_q    <= op_key_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
      resp_err_q  <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_aes_arb_ctrl.sv
// Self-checking bench for aes_arb_ctrl with a latency-programmable AES core stand-in.
module tb_aes_arb_ctrl;

  localparam int TimeoutCyc = 100;
  localparam int GapCyc     = 2;
  localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic AES_clk = 1'b0;
  logic AES_rst_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_data, req0_key, req1_data, req1_key;
  logic resp_valid, resp_ready, resp_id, resp_err;
  logic [127:0] resp_data, core_data_in, core_key_in, core_data_out;
  logic core_en, core_data_out_valid;

  int checks = 0;
  int errors = 0;
  int last_gnt = 1;  // model: requester granted last; 1 means req0 wins next tie
  int unsigned lat = 0;
  int unsigned ccnt;
  bit never = 0;
  bit spurious = 0;

  aes_arb_ctrl #(.TIMEOUT_CYC(TimeoutCyc), .GAP_CYC(GapCyc)) dut (
    .AES_clk(AES_clk), .AES_rst_n(AES_rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_err(resp_err),
    .resp_data(resp_data), .core_en(core_en), .core_data_in(core_data_in),
    .core_key_in(core_key_in), .core_data_out(core_data_out),
    .core_data_out_valid(core_data_out_valid)
  );

  initial forever #5 AES_clk = ~AES_clk;

  // Stand-in cipher: the known FIPS-197 vector, otherwise an arbitrary keyed scramble.
  function automatic logic [127:0] cipher(input logic [127:0] d, input logic [127:0] k);
    if (d == FipsPt && k == FipsKey) return FipsCt;
    return {d[63:0], d[127:64]} ^ k ^ 128'h5a5a_0f0f_3c3c_9696_a5a5_f0f0_c3c3_6969;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Core stand-in: result valid 'lat' cycles after core_en rises.
  always @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n)    ccnt <= 0;
    else if (!core_en) ccnt <= 0;
    else               ccnt <= ccnt + 1;
  end
  assign core_data_out_valid = spurious | (!never && core_en && (ccnt == lat));
  assign core_data_out = spurious ? 128'hdead_beef_dead_beef_dead_beef_dead_beef
                                  : cipher(core_data_in, core_key_in);

  task automatic apply_reset();
    AES_rst_n = 1'b0; req0_valid = 0; req1_valid = 0; resp_ready = 0; never = 0; spurious = 0;
    repeat (2) @(negedge AES_clk);
    AES_rst_n = 1'b1;
    last_gnt = 1;
  endtask

  // Call at a falling edge; returns 1 ns after the falling edge where a ready was seen.
  task automatic wait_grant(output int who, output bit ok);
    ok = 0; who = 0;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (req0_ready || req1_ready) begin ok = 1; who = int'(req1_ready); return; end
      @(negedge AES_clk);
    end
  endtask

  task automatic wait_resp(output bit ok);
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge AES_clk); #1;
      if (resp_valid) begin ok = 1; return; end
    end
  endtask

  task automatic test_reset();
    AES_rst_n = 0; req0_valid = 1; req1_valid = 1; resp_ready = 1;
    req0_data = rand128(); req0_key = rand128(); req1_data = rand128(); req1_key = rand128();
    repeat (2) @(negedge AES_clk); #1;
    checks++;
    if ({req0_ready, req1_ready, resp_valid, resp_id, resp_err, core_en} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {req0_ready, req1_ready, resp_valid, resp_id, resp_err, core_en});
    end
    checks++;
    if (resp_data !== '0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
    checks++;
    if (core_data_in !== '0) begin errors++; $display("FAIL reset_core_data: got %h expected 0", core_data_in); end
    checks++;
    if (core_key_in !== '0) begin errors++; $display("FAIL reset_core_key: got %h expected 0", core_key_in); end
    req0_valid = 0; req1_valid = 0;
    @(negedge AES_clk);
    AES_rst_n = 1; req0_valid = 1; req1_valid = 1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL first_tie: got %b expected 01", {req1_ready, req0_ready});
    end
    apply_reset();
  endtask

  task automatic test_single();
    int who; bit ok;
    apply_reset();
    lat = 4; resp_ready = 1;
    req0_data = FipsPt; req0_key = FipsKey; req0_valid = 1;
    wait_grant(who, ok);
    checks++;
    if (!ok || who != 0 || req1_ready) begin
      errors++; $display("FAIL single_grant: got ok=%0d who=%0d expected ok=1 who=0", ok, who);
    end
    @(negedge AES_clk); req0_valid = 0; #1;
    checks++;
    if ({req0_ready, core_en} !== 2'b01 || core_data_in !== FipsPt || core_key_in !== FipsKey) begin
      errors++;
      $display("FAIL single_run: got rdy=%b en=%b d=%h expected rdy=0 en=1 d=%h",
               req0_ready, core_en, core_data_in, FipsPt);
    end
    wait_resp(ok);
    checks++;
    if (!ok || resp_id !== 1'b0 || resp_err !== 1'b0 || resp_data !== FipsCt) begin
      errors++;
      $display("FAIL single_resp: got ok=%0d id=%b err=%b data=%h expected 1 0 0 %h",
               ok, resp_id, resp_err, resp_data, FipsCt);
    end
    last_gnt = 0;
  endtask

  task automatic test_contention();
    int exp_id_q[$];
    logic [127:0] exp_ct_q[$];
    logic [127:0] op_d, op_k;
    int order[4] = '{0, 1, 0, 1};
    int refresh = -1, prev_g = -1, ng = 0, nr = 0, low_run = 0, bad_op = 0, who, exp_w;
    bit seen_run = 0;
    apply_reset();
    lat = 3; resp_ready = 1;
    req0_data = rand128(); req0_key = rand128(); req1_data = rand128(); req1_key = rand128();
    req0_valid = 1; req1_valid = 1;
    op_d = '0; op_k = '0;
    for (int it = 0; it < 200 && nr < 4; it++) begin
      if (it > 0) @(negedge AES_clk);
      if (refresh == 0) begin req0_data = rand128(); req0_key = rand128(); end
      if (refresh == 1) begin req1_data = rand128(); req1_key = rand128(); end
      refresh = -1;
      if (ng == 4) begin req0_valid = 0; req1_valid = 0; end
      #1;
      if (core_en) begin
        if (seen_run && low_run > 0) begin
          checks++;
          if (low_run < GapCyc) begin
            errors++; $display("FAIL gap_low: got %0d cycles expected >= %0d", low_run, GapCyc);
          end
        end
        low_run = 0; seen_run = 1;
        if (core_data_in !== op_d || core_key_in !== op_k) bad_op++;
      end else low_run++;
      if (req0_ready || req1_ready) begin
        who = int'(req1_ready);
        exp_w = 1 - last_gnt;
        checks++;
        if ((req0_ready && req1_ready) || who != exp_w || who != order[ng]) begin
          errors++; $display("FAIL rr_order: got %b at grant %0d expected id %0d",
                             {req1_ready, req0_ready}, ng, order[ng]);
        end
        if (prev_g >= 0) begin
          checks++;
          if (it - prev_g != int'(lat) + 5) begin
            errors++; $display("FAIL turnaround: got %0d expected %0d", it - prev_g, lat + 5);
          end
        end
        prev_g = it;
        op_d = who ? req1_data : req0_data;
        op_k = who ? req1_key : req0_key;
        exp_id_q.push_back(who); exp_ct_q.push_back(cipher(op_d, op_k));
        last_gnt = who; refresh = who; ng++;
      end
      if (resp_valid) begin
        checks++;
        if (exp_id_q.size() == 0) begin
          errors++; $display("FAIL cont_resp: got unexpected resp expected none");
        end else begin
          if (resp_id !== 1'(exp_id_q[0]) || resp_err !== 1'b0 || resp_data !== exp_ct_q[0]) begin
            errors++; $display("FAIL cont_resp: got id=%b err=%b data=%h expected %0d 0 %h",
                               resp_id, resp_err, resp_data, exp_id_q[0], exp_ct_q[0]);
          end
          void'(exp_id_q.pop_front()); void'(exp_ct_q.pop_front()); nr++;
        end
      end
    end
    checks++;
    if (nr != 4 || bad_op != 0) begin
      errors++; $display("FAIL cont_done: got resp=%0d op_glitches=%0d expected 4 0", nr, bad_op);
    end
  endtask

  task automatic test_backpressure();
    int who, bad = 0; bit ok; logic [127:0] d, k, exp;
    apply_reset();
    lat = 5; resp_ready = 0;
    d = rand128(); k = rand128(); exp = cipher(d, k);
    req1_data = d; req1_key = k; req1_valid = 1;
    wait_grant(who, ok);
    checks++;
    if (!ok || who != 1) begin errors++; $display("FAIL bp_grant: got who=%0d expected 1", who); end
    @(negedge AES_clk);
    req1_valid = 0; req0_valid = 1; req0_data = rand128(); req0_key = rand128();
    wait_resp(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_resp: got no resp_valid expected resp_valid"); end
    for (int i = 0; i < 20; i++) begin
      @(negedge AES_clk); spurious = (i == 7); #1;
      checks++;
      if ({resp_valid, resp_id, resp_err, core_en, req0_ready, req1_ready} !== 6'b110000 ||
          resp_data !== exp) begin
        errors++;
        $display("FAIL bp_hold: got v/id/err/en/r0/r1=%b data=%h expected 110000 %h",
                 {resp_valid, resp_id, resp_err, core_en, req0_ready, req1_ready}, resp_data, exp);
      end
    end
    @(negedge AES_clk); spurious = 0; resp_ready = 1;
    @(negedge AES_clk); req0_valid = 0; #1;
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b expected 0", resp_valid); end
    for (int i = 0; i < 6; i++) begin
      @(negedge AES_clk); #1;
      if (req0_ready || req1_ready || core_en || resp_valid) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL drop_valid: got %0d busy cycles expected 0", bad); end
  endtask

  task automatic test_timeout();
    for (int c = 0; c < 2; c++) begin
      int who, n, bad; bit ok; logic [127:0] d, k, exp;
      apply_reset();
      never = (c == 0); lat = TimeoutCyc - 1; resp_ready = 1;
      d = rand128(); k = rand128();
      exp = (c == 0) ? 128'h0 : cipher(d, k);
      if (c == 0) begin req0_data = d; req0_key = k; req0_valid = 1; end
      else        begin req1_data = d; req1_key = k; req1_valid = 1; end
      wait_grant(who, ok);
      checks++;
      if (!ok || who != c) begin errors++; $display("FAIL to_grant: got who=%0d expected %0d", who, c); end
      n = 0; bad = 0;
      do begin
        @(negedge AES_clk); req0_valid = 0; req1_valid = 0; #1; n++;
        if (!resp_valid && (!core_en || core_data_in !== d || core_key_in !== k)) bad++;
      end while (!resp_valid && n < 150);
      checks++;
      if (n != TimeoutCyc + 1 || bad != 0) begin
        errors++; $display("FAIL to_latency: got %0d unstable=%0d expected %0d 0", n, bad, TimeoutCyc + 1);
      end
      checks++;
      if (resp_id !== 1'(c) || resp_err !== (c == 0) || resp_data !== exp) begin
        errors++; $display("FAIL to_resp: got id=%b err=%b data=%h expected %0d %0d %h",
                           resp_id, resp_err, resp_data, c, c == 0, exp);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int who, bad = 0; bit ok; logic [127:0] d, k;
    apply_reset();
    lat = 30; resp_ready = 1;
    req0_data = rand128(); req0_key = rand128(); req0_valid = 1;
    wait_grant(who, ok);
    for (int i = 0; i < 10; i++) begin @(negedge AES_clk); req0_valid = 0; end
    @(negedge AES_clk); AES_rst_n = 0; #1;
    checks++;
    if ({resp_valid, resp_id, resp_err, core_en, req0_ready, req1_ready} !== 6'b0 ||
        core_data_in !== '0 || core_key_in !== '0 || resp_data !== '0) begin
      errors++; $display("FAIL midrun_reset: got en=%b v=%b din=%h expected all zero",
                         core_en, resp_valid, core_data_in);
    end
    repeat (2) @(negedge AES_clk);
    AES_rst_n = 1; last_gnt = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge AES_clk); #1;
      if (resp_valid || core_en) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL aborted_job: got %0d active cycles expected 0", bad); end
    @(negedge AES_clk);
    lat = 5; d = rand128(); k = rand128();
    req1_data = d; req1_key = k; req1_valid = 1;
    wait_grant(who, ok);
    checks++;
    if (!ok || who != 1) begin errors++; $display("FAIL post_reset_grant: got who=%0d expected 1", who); end
    @(negedge AES_clk); req1_valid = 0;
    wait_resp(ok);
    checks++;
    if (!ok || resp_id !== 1'b1 || resp_err !== 1'b0 || resp_data !== cipher(d, k)) begin
      errors++; $display("FAIL post_reset_resp: got id=%b err=%b data=%h expected 1 0 %h",
                         resp_id, resp_err, resp_data, cipher(d, k));
    end
  endtask

  task automatic test_random();
    int exp_id_q[$];
    logic [127:0] exp_ct_q[$];
    logic [127:0] op_d = '0, op_k = '0;
    bit busy = 0, any_v;
    int idle_from = 0, who, exp_w, jobs = 0;
    apply_reset();
    for (int it = 0; it < 600; it++) begin
      if (it > 0) @(negedge AES_clk);
      req0_valid = ($urandom_range(0, 2) != 0); req1_valid = ($urandom_range(0, 2) != 0);
      req0_data = rand128(); req0_key = rand128(); req1_data = rand128(); req1_key = rand128();
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      any_v = req0_valid | req1_valid;
      checks++;
      if ((req0_ready | req1_ready) !== (!busy && it >= idle_from && any_v) ||
          (req0_ready & req1_ready)) begin
        errors++; $display("FAIL rnd_ready: got %b at cycle %0d expected grant=%0d", {req1_ready,
                           req0_ready}, it, !busy && it >= idle_from && any_v);
      end
      if (core_en) begin
        checks++;
        if (core_data_in !== op_d || core_key_in !== op_k) begin
          errors++; $display("FAIL rnd_operand: got %h expected %h", core_data_in, op_d);
        end
      end
      if (req0_ready || req1_ready) begin
        who = int'(req1_ready);
        exp_w = (req0_valid && req1_valid) ? 1 - last_gnt : int'(req1_valid);
        checks++;
        if (who != exp_w) begin errors++; $display("FAIL rnd_winner: got %0d expected %0d", who, exp_w); end
        op_d = who ? req1_data : req0_data;
        op_k = who ? req1_key : req0_key;
        exp_id_q.push_back(who); exp_ct_q.push_back(cipher(op_d, op_k));
        last_gnt = who; busy = 1; lat = $urandom_range(0, 6);
      end
      if (resp_valid) begin
        checks++;
        if (exp_id_q.size() == 0) begin
          errors++; $display("FAIL rnd_resp: got unexpected resp expected none");
        end else begin
          if (resp_id !== 1'(exp_id_q[0]) || resp_err !== 1'b0 || resp_data !== exp_ct_q[0]) begin
            errors++; $display("FAIL rnd_resp: got id=%b err=%b data=%h expected %0d 0 %h",
                               resp_id, resp_err, resp_data, exp_id_q[0], exp_ct_q[0]);
          end
          if (resp_ready) begin
            void'(exp_id_q.pop_front()); void'(exp_ct_q.pop_front());
            busy = 0; idle_from = it + GapCyc + 1; jobs++;
          end
        end
      end
    end
    checks++;
    if (jobs < 10) begin errors++; $display("FAIL rnd_progress: got %0d jobs expected >= 10", jobs); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    AES_rst_n = 0; req0_valid = 0; req1_valid = 0; resp_ready = 0;
    req0_data = '0; req0_key = '0; req1_data = '0; req1_key = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_timeout();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
